// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an NDIG-digit
// common-anode 7-segment display. One shared bcd7seg decoder, anti-ghost
// blanking slots between digits, and a pending/shadow double buffer so a
// frame never mixes old and new digits.
// Optional macro SEG_LZ_BLANK_EN: blank leading zero digits (digit 0 always lit).

module bcd7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);
    // Map a BCD digit to active-low segments a..g; non-BCD codes show an error glyph
    always_comb begin
        case (bcd)
            4'd0:    seg_n = 7'b000_0001;
            4'd1:    seg_n = 7'b100_1111;
            4'd2:    seg_n = 7'b001_0010;
            4'd3:    seg_n = 7'b000_0110;
            4'd4:    seg_n = 7'b100_1100;
            4'd5:    seg_n = 7'b010_0100;
            4'd6:    seg_n = 7'b010_0000;
            4'd7:    seg_n = 7'b000_1111;
            4'd8:    seg_n = 7'b000_0000;
            4'd9:    seg_n = 7'b000_0100;
            default: seg_n = 7'b000_1001;
        endcase
    end
endmodule

module seg_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] bcd_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              en,
    output logic [NDIG-1:0]   an_n,
    output logic [6:0]        seg_n,
    output logic              frame_done
);
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic [IW-1:0] IDX_ZERO   = IW'(0);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
    // With no blanking time every slot change goes straight to the next digit
    localparam state_t        SLOT_START = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*NDIG-1:0]   pend_q, pend_d;
    logic                pend_v_q, pend_v_d;
    logic [4*NDIG-1:0]   shadow_q, shadow_d;
    logic                ld_ready_q, ld_ready_d;
    logic [NDIG-1:0]     an_n_q, an_n_d;
    logic [6:0]          seg_n_q, seg_n_d;
    logic                frame_done_q, frame_done_d;
    logic                boundary_s;
    logic                lit_s;
    logic [3:0]          digit_s;
    logic [6:0]          dec_seg_s;

    // Decode the digit of the slot being entered so pins update on the entry edge
    assign digit_s = shadow_d[4*int'(idx_d) +: 4];

    bcd7seg u_dec (
        .bcd   (digit_s),
        .seg_n (dec_seg_s)
    );

    // Slot sequencer: state, digit index and slot counter
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        boundary_s   = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_OFF: begin
                    idx_d      = IDX_ZERO;
                    cnt_d      = CNT_ZERO;
                    boundary_s = 1'b1;
                    state_d    = SLOT_START;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = SLOT_START;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = IDX_ZERO;
                            frame_done_d = 1'b1;
                            boundary_s   = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Double buffer: accept loads into pending, move pending to shadow at frame boundaries
    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        shadow_d = shadow_q;
        if (boundary_s && pend_v_q) begin
            shadow_d = pend_q;
            pend_v_d = 1'b0;
        end else if (ld_valid && !pend_v_q) begin
            pend_d   = bcd_in;
            pend_v_d = 1'b1;
        end else begin
            shadow_d = shadow_q;
        end
        ld_ready_d = ~pend_v_d;
    end

    // Decide whether the digit being entered is lit (leading-zero suppression optional)
    always_comb begin
`ifdef SEG_LZ_BLANK_EN
        lit_s = (idx_d == IDX_ZERO);
        for (int k = 0; k < NDIG; k++) begin
            if ((k >= int'(idx_d)) && (shadow_d[4*k +: 4] != 4'h0)) begin
                lit_s = 1'b1;
            end else begin
                lit_s = lit_s;
            end
        end
`else
        lit_s = 1'b1;
`endif
    end

    // Next pin values: one-hot-low anode and decoded segments only while showing
    always_comb begin
        an_n_d  = {NDIG{1'b1}};
        seg_n_d = 7'h7F;
        if ((state_d == ST_SHOW) && lit_s) begin
            an_n_d[idx_d] = 1'b0;
            seg_n_d       = dec_seg_s;
        end else begin
            an_n_d  = {NDIG{1'b1}};
            seg_n_d = 7'h7F;
        end
    end

    // State and output registers; reset blanks the pins and drops any pending load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            idx_q        <= IDX_ZERO;
            cnt_q        <= CNT_ZERO;
            pend_q       <= {(4*NDIG){1'b0}};
            pend_v_q     <= 1'b0;
            shadow_q     <= {(4*NDIG){1'b0}};
            ld_ready_q   <= 1'b1;
            an_n_q       <= {NDIG{1'b1}};
            seg_n_q      <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            shadow_q     <= shadow_d;
            ld_ready_q   <= ld_ready_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
- Shares one bcd7seg decoder instance across all digits and sequences anode enables with anti-ghost blanking slots.
- Accepts new display values through a valid/ready load port and double-buffers them so a frame never shows a mix of old and new digits.
- Sits between the number-producing logic and the board segment and anode pins.

Parameters:
- NDIG, 4, number of digits; range 1..8.
- SCAN_DIV, 1000, clock cycles each digit is lit (SHOW slot); must be >= 1.
- BLANK_CYC, 4, clock cycles all anodes are off between digits; 0 removes the BLANK slot.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bcd_in  in  4*NDIG  packed BCD value; digit k = bcd_in[4k+3:4k]; digit 0 is least significant.
- ld_valid  in  1  load request; qualifies bcd_in.
- ld_ready  out  1  pending buffer free; a load is accepted when ld_valid & ld_ready.
- en  in  1  scan enable.
- an_n  out  NDIG  anode select, active-low, one-hot-low while a digit is shown.
- seg_n  out  7  segments, active-low; bit6=a … bit0=g; output of the shared bcd7seg.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - an_n = all 1, seg_n = 7'h7F, ld_ready = 1, frame_done = 0.
  - Pending buffer and shadow buffer = 0; pend_v = 0; digit index idx = 0; slot counter = 0; state = OFF.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Buffers:
  - Load accept copies bcd_in into pending and sets pend_v. ld_ready = ~pend_v, so there is never a simultaneous accept and transfer.
  - At a frame boundary, if pend_v = 1: shadow <= pending and pend_v clears.
  - The decoder input is always shadow[idx].
- Decode map (via bcd7seg):
  - 0:000_0001, 1:100_1111, 2:001_0010, 3:000_0110, 4:100_1100.
  - 5:010_0100, 6:010_0000, 7:000_1111, 8:000_0000, 9:000_0100.
  - 4'hA–4'hF: 000_1001 (error glyph).
- State machine:
  - OFF: outputs blank. If en=1: idx <= 0, do a frame-boundary buffer transfer, then go to BLANK (or directly to SHOW if BLANK_CYC = 0).
  - BLANK: an_n all 1, seg_n 7'h7F for exactly BLANK_CYC cycles, then SHOW.
  - SHOW: an_n[idx] = 0, others 1; seg_n = decode(shadow[idx]); lasts exactly SCAN_DIV cycles.
  - End of SHOW with idx < NDIG-1: idx <= idx+1, go to BLANK/SHOW.
  - End of SHOW with idx = NDIG-1: idx <= 0, frame_done = 1 for one cycle, do a frame-boundary buffer transfer, go to BLANK/SHOW.
  - an_n and seg_n are registered. They take the new slot's values on the same edge the state is entered, so there is no combinational path from bcd_in to the pins.
- Timing:
  - Frame period = NDIG*(SCAN_DIV+BLANK_CYC) cycles.
  - Slot counter width = $clog2(max(SCAN_DIV,BLANK_CYC)+1); the counter wraps to 0 on every slot change.
- en=0 in any state: the next edge goes to OFF with outputs blanked. idx, shadow and pending are retained. Re-enable always restarts at digit 0.
- Reset asserted mid-frame: pins blank immediately (asynchronously). A pending load is discarded.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: digits more significant than the highest nonzero shadow digit are blanked.
  - In their SHOW slot, an_n stays all 1 and seg_n = 7'h7F; slot timing is unchanged.
  - Digit 0 is always shown.
  - A digit >= 4'hA counts as nonzero.
- Undefined: all NDIG digits are always shown.

Test Plan:
- All tests use NDIG=4, SCAN_DIV=3, BLANK_CYC=1.
- Reset: hold rst_n=0 mid-scan -> an_n=4'hF, seg_n=7'h7F, ld_ready=1, frame_done=0 immediately.
- Basic scan: load 16'h1234, set en=1, first frame cycles -> BLANK 1 cycle; an_n=4'b1110, seg_n=100_1100 (4) for 3 cycles; blank 1; an_n=4'b1101, seg_n=000_0110 (3); then 2 and 1. frame_done pulses every 16 cycles.
- Double buffering: load 16'h5678 mid-frame -> ld_ready=0 until the frame boundary; a second ld_valid is held off; digits 1–3 still show 1234 values; 8 first appears on digit 0 of the next frame.
- Error glyph: load 16'h00B0 -> digit 1 slot shows seg_n=000_1001 with an_n=4'b1101.
- Enable drop: en=0 during digit 2 SHOW -> next cycle an_n=4'hF, seg_n=7'h7F. Re-enable -> the first lit slot is digit 0.
- SEG_LZ_BLANK_EN: 16'h0070 -> digits 3 and 2 blank, digit 1 shows 000_1111, digit 0 shows 000_0001. 16'h0000 -> only digit 0 lit, showing 0.
